// File: rtl/timer_multi_wb8.sv
// rtl/timer_multi_wb8.sv - multi-channel compare timer on an 8-bit Wishbone bus
//
// Free-running 32-bit tick counter (CLOCKFREQ/TICKHZ prescaler), CHANNELS
// compare channels (one-shot or periodic auto-reload), pending/enable masks
// folded into one registered level interrupt.
//
// Optional feature macro: TIMER_CAPTURE_EN (adds I_capture, CAPTURE at 56..59,
// CAPFLAG at 60, interrupt enable on IE bit7; CHANNELS limited to 6).
//
// Ports:
//   CLK_I        system clock
//   RST_N_I      asynchronous active-low reset
//   ADR_I[5:0]   byte address
//   DAT_I[7:0]   write data
//   STB_I        strobe
//   WE_I         write enable
//   ACK_O        acknowledge (STB_I delayed one cycle)
//   DAT_O[7:0]   registered read data
//   O_interrupt  level interrupt request
//   I_capture    asynchronous capture input (TIMER_CAPTURE_EN only)

module timer_multi_wb8 #(
    parameter int CLOCKFREQ = 25000000,
    parameter int TICKHZ    = 1000,
    parameter int CHANNELS  = 4
) (
    input  logic       CLK_I,
    input  logic       RST_N_I,
    input  logic [5:0] ADR_I,
    input  logic [7:0] DAT_I,
    input  logic       STB_I,
    input  logic       WE_I,
    output logic       ACK_O,
    output logic [7:0] DAT_O,
    output logic       O_interrupt
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic       I_capture
`endif
);

    localparam int DIV = CLOCKFREQ / TICKHZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
`ifdef TIMER_CAPTURE_EN
    localparam logic [7:0] IE_MASK = 8'((1 << CHANNELS) - 1) | 8'h80;
`else
    localparam logic [7:0] IE_MASK = 8'((1 << CHANNELS) - 1);
`endif

    logic [PW-1:0]       pre_q, pre_d;
    logic [31:0]         ticks_q, ticks_d;
    logic [23:0]         snap_q, snap_d;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [7:0]          ie_q, ie_d;
    logic                ack_q, ack_d;
    logic [7:0]          dat_q, dat_d;
    logic                irq_q, irq_d;

    logic [31:0]         cmp_q [CHANNELS];
    logic [31:0]         cmp_d [CHANNELS];
    logic [15:0]         per_q [CHANNELS];
    logic [15:0]         per_d [CHANNELS];
    logic [CHANNELS-1:0] armed_q, armed_d;
    logic [CHANNELS-1:0] periodic_q, periodic_d;

    logic [CHANNELS-1:0] match_set;
    logic [CHANNELS-1:0] w1c;
    logic [7:0]          rdata;
    logic                wr, rd;
    logic                irq_cap;

`ifdef TIMER_CAPTURE_EN
    logic        sync1_q, sync2_q, sync3_q;
    logic [31:0] cap_q, cap_d;
    logic        capflag_q, capflag_d;
`endif

    assign wr = STB_I & WE_I;
    assign rd = STB_I & ~WE_I;

    always_comb begin
        pre_d      = pre_q;
        ticks_d    = ticks_q;
        snap_d     = snap_q;
        ie_d       = ie_q;
        cmp_d      = cmp_q;
        per_d      = per_q;
        armed_d    = armed_q;
        periodic_d = periodic_q;
        match_set  = '0;
        w1c        = '0;
        rdata      = 8'h00;
        irq_cap    = 1'b0;

        // Prescaler and tick counter
        if (pre_q == PRE_LAST) begin
            pre_d   = '0;
            ticks_d = ticks_q + 32'd1;
        end else begin
            pre_d = pre_q + PW'(1);
        end

        // Compare matches. A periodic hit moves COMPARE forward so the
        // following cycle no longer matches; one-shot hits disarm. Either
        // way pending is set exactly once per event.
        for (int c = 0; c < CHANNELS; c++) begin
            if (armed_q[c] && (ticks_q == cmp_q[c])) begin
                match_set[c] = 1'b1;
                if (!periodic_q[c] || (per_q[c] == 16'd0)) begin
                    armed_d[c] = 1'b0;
                end else begin
                    cmp_d[c] = cmp_q[c] + {16'd0, per_q[c]};
                end
            end
        end

        // Bus writes are applied after match updates so they win on the
        // byte/field they touch while other match effects survive.
        if (wr) begin
            if (ADR_I == 6'd4) w1c = DAT_I[CHANNELS-1:0];
            if (ADR_I == 6'd5) ie_d = DAT_I & IE_MASK;
            for (int c = 0; c < CHANNELS; c++) begin
                if (ADR_I[5:3] == 3'(c + 1)) begin
                    case (ADR_I[2:0])
                        3'd0: cmp_d[c][7:0]   = DAT_I;
                        3'd1: cmp_d[c][15:8]  = DAT_I;
                        3'd2: cmp_d[c][23:16] = DAT_I;
                        3'd3: begin
                            cmp_d[c][31:24] = DAT_I;
                            armed_d[c]      = 1'b1;
                        end
                        3'd4: begin
                            armed_d[c]    = DAT_I[0];
                            periodic_d[c] = DAT_I[1];
                        end
                        3'd5: per_d[c][7:0]  = DAT_I;
                        3'd6: per_d[c][15:8] = DAT_I;
                        default: ;
                    endcase
                end
            end
        end

        // Set beats clear when both hit the same pending bit.
        pend_d = (pend_q & ~w1c) | match_set;

        // Read mux. Byte 0 snapshots the upper bytes so a multi-byte read
        // of ticks is coherent.
        if (ADR_I[5:3] == 3'd0) begin
            case (ADR_I[2:0])
                3'd0: rdata = ticks_q[7:0];
                3'd1: rdata = snap_q[7:0];
                3'd2: rdata = snap_q[15:8];
                3'd3: rdata = snap_q[23:16];
                3'd4: rdata = 8'(pend_q);
                3'd5: rdata = ie_q;
                default: rdata = 8'h00;
            endcase
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (ADR_I[5:3] == 3'(c + 1)) begin
                case (ADR_I[2:0])
                    3'd0: rdata = cmp_q[c][7:0];
                    3'd1: rdata = cmp_q[c][15:8];
                    3'd2: rdata = cmp_q[c][23:16];
                    3'd3: rdata = cmp_q[c][31:24];
                    3'd4: rdata = {6'd0, periodic_q[c], armed_q[c]};
                    3'd5: rdata = per_q[c][7:0];
                    3'd6: rdata = per_q[c][15:8];
                    default: rdata = 8'h00;
                endcase
            end
        end
        if (rd && (ADR_I == 6'd0)) snap_d = ticks_q[31:8];

`ifdef TIMER_CAPTURE_EN
        cap_d     = cap_q;
        capflag_d = capflag_q;
        if (ADR_I[5:3] == 3'd7) begin
            case (ADR_I[2:0])
                3'd0: rdata = cap_q[7:0];
                3'd1: rdata = cap_q[15:8];
                3'd2: rdata = cap_q[23:16];
                3'd3: rdata = cap_q[31:24];
                3'd4: rdata = {7'd0, capflag_q};
                default: rdata = 8'h00;
            endcase
        end
        if (rd && (ADR_I == 6'd56)) capflag_d = 1'b0;
        // A new capture event beats the read-clear of the previous one.
        if (sync2_q && !sync3_q) begin
            cap_d     = ticks_q;
            capflag_d = 1'b1;
        end
        irq_cap = capflag_q & ie_q[7];
`endif

        ack_d = STB_I;
        dat_d = rd ? rdata : 8'h00;
        irq_d = (|(pend_q & ie_q[CHANNELS-1:0])) | irq_cap;
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            pre_q      <= '0;
            ticks_q    <= '0;
            snap_q     <= '0;
            pend_q     <= '0;
            ie_q       <= '0;
            ack_q      <= 1'b0;
            dat_q      <= 8'h00;
            irq_q      <= 1'b0;
            armed_q    <= '0;
            periodic_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                cmp_q[c] <= '0;
                per_q[c] <= '0;
            end
        end else begin
            pre_q      <= pre_d;
            ticks_q    <= ticks_d;
            snap_q     <= snap_d;
            pend_q     <= pend_d;
            ie_q       <= ie_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            irq_q      <= irq_d;
            armed_q    <= armed_d;
            periodic_q <= periodic_d;
            cmp_q      <= cmp_d;
            per_q      <= per_d;
        end
    end

`ifdef TIMER_CAPTURE_EN
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            cap_q     <= '0;
            capflag_q <= 1'b0;
        end else begin
            sync1_q   <= I_capture;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            cap_q     <= cap_d;
            capflag_q <= capflag_d;
        end
    end
`endif

    assign ACK_O       = ack_q;
    assign DAT_O       = dat_q;
    assign O_interrupt = irq_q;

endmodule

// File: tb/tb_timer_multi_wb8.sv
// tb/tb_timer_multi_wb8.sv - directed self-checking bench for timer_multi_wb8

module tb_timer_multi_wb8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] adr = '0;
    logic [7:0] dat_w = '0;
    logic       stb = 1'b0;
    logic       we = 1'b0;
    logic       ack;
    logic [7:0] dat_r;
    logic       irq;
`ifdef TIMER_CAPTURE_EN
    logic       cap_in = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    timer_multi_wb8 #(
        .CLOCKFREQ(10000),
        .TICKHZ   (1000),
        .CHANNELS (4)
    ) dut (
        .CLK_I      (clk),
        .RST_N_I    (rst_n),
        .ADR_I      (adr),
        .DAT_I      (dat_w),
        .STB_I      (stb),
        .WE_I       (we),
        .ACK_O      (ack),
        .DAT_O      (dat_r),
        .O_interrupt(irq)
`ifdef TIMER_CAPTURE_EN
        ,
        .I_capture  (cap_in)
`endif
    );

    always #5 clk = ~clk;

    // Edges since reset release; ticks before edge E equal (E-1)/10.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        stb   = 1'b0;
        we    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        adr   = a;
        dat_w = d;
        we    = 1'b1;
        stb   = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [7:0] d, output logic k);
        @(negedge clk);
        adr = a;
        we  = 1'b0;
        stb = 1'b1;
        @(posedge clk);
        #1;
        d   = dat_r;
        k   = ack;
        stb = 1'b0;
    endtask

    logic [7:0] rv;
    logic       rk;

    initial begin
        // Reset state
        #2;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", {24'd0, dat_r}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        do_reset();

        // 1: tick counter and byte-0 snapshot
        wait_cyc(250);
        bus_read(6'd0, rv, rk);
        check("t1_b0", {24'd0, rv}, 32'd25);
        check("t1_ack", {31'd0, rk}, 32'd1);
        bus_read(6'd1, rv, rk); check("t1_b1", {24'd0, rv}, 32'd0);
        bus_read(6'd2, rv, rk); check("t1_b2", {24'd0, rv}, 32'd0);
        bus_read(6'd3, rv, rk); check("t1_b3", {24'd0, rv}, 32'd0);
        wait_cyc(2570);
        bus_read(6'd1, rv, rk); check("t1_snap_hold", {24'd0, rv}, 32'd0);
        bus_read(6'd0, rv, rk); check("t1_b0_257", {24'd0, rv}, 32'd1);
        bus_read(6'd1, rv, rk); check("t1_snap_new", {24'd0, rv}, 32'd1);
        bus_read(6'd6, rv, rk); check("t1_addr6", {24'd0, rv}, 32'd0);
        bus_write(6'd40, 8'h55);
        bus_read(6'd40, rv, rk); check("t1_unmapped", {24'd0, rv}, 32'd0);

        // 2: one-shot on ch0 at 40
        do_reset();
        bus_write(6'd8, 8'd40);
        bus_write(6'd11, 8'd0);
        bus_write(6'd5, 8'h01);
        bus_read(6'd12, rv, rk); check("t2_armed", {24'd0, rv}, 32'h01);
        bus_read(6'd8, rv, rk);  check("t2_cmp", {24'd0, rv}, 32'd40);
        wait_cyc(400);
        bus_read(6'd4, rv, rk);  check("t2_pend_pre", {24'd0, rv}, 32'd0);
        check("t2_irq_pre", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("t2_irq_set", {31'd0, irq}, 32'd1);
        bus_read(6'd4, rv, rk);  check("t2_pend", {24'd0, rv}, 32'h01);
        bus_read(6'd12, rv, rk); check("t2_disarmed", {24'd0, rv}, 32'h00);
        bus_write(6'd4, 8'h01);
        @(posedge clk); #1;
        check("t2_irq_clr", {31'd0, irq}, 32'd0);

        // 3: periodic ch1, period 10 from 100, then period 0
        do_reset();
        bus_write(6'd16, 8'd100);
        bus_write(6'd19, 8'd0);
        bus_write(6'd21, 8'd10);
        bus_write(6'd20, 8'h03);
        bus_write(6'd5, 8'h02);
        wait_cyc(1005);
        bus_read(6'd16, rv, rk); check("t3_cmp110", {24'd0, rv}, 32'd110);
        bus_read(6'd4, rv, rk);  check("t3_pend100", {24'd0, rv}, 32'h02);
        bus_write(6'd4, 8'h02);
        wait_cyc(1099);
        bus_read(6'd4, rv, rk);  check("t3_once", {24'd0, rv}, 32'h00);
        wait_cyc(1105);
        bus_read(6'd4, rv, rk);  check("t3_pend110", {24'd0, rv}, 32'h02);
        bus_write(6'd4, 8'h02);
        bus_read(6'd16, rv, rk); check("t3_cmp120", {24'd0, rv}, 32'd120);
        bus_write(6'd21, 8'd0);
        wait_cyc(1205);
        bus_read(6'd4, rv, rk);  check("t3_pend120", {24'd0, rv}, 32'h02);
        bus_read(6'd20, rv, rk); check("t3_ctrl_p0", {24'd0, rv}, 32'h02);
        bus_read(6'd16, rv, rk); check("t3_cmp_hold", {24'd0, rv}, 32'd120);
        bus_write(6'd4, 8'h02);
        wait_cyc(1400);
        bus_read(6'd4, rv, rk);  check("t3_no_more", {24'd0, rv}, 32'h00);

        // 4: simultaneous match vs W1C, and disarm write vs match
        do_reset();
        bus_write(6'd8, 8'd20);
        bus_write(6'd11, 8'd0);
        bus_write(6'd16, 8'd30);
        bus_write(6'd19, 8'd0);
        bus_write(6'd21, 8'd5);
        bus_write(6'd20, 8'h03);
        wait_cyc(200);
        bus_write(6'd4, 8'h01);
        bus_read(6'd4, rv, rk);  check("t4_set_wins", {24'd0, rv}, 32'h01);
        wait_cyc(300);
        bus_write(6'd20, 8'h00);
        bus_read(6'd4, rv, rk);  check("t4_pend_both", {24'd0, rv}, 32'h03);
        bus_read(6'd20, rv, rk); check("t4_ctrl_wr", {24'd0, rv}, 32'h00);
        bus_read(6'd16, rv, rk); check("t4_cmp_adv", {24'd0, rv}, 32'd35);

        // 5: async reset in the middle of a read strobe
        do_reset();
        bus_write(6'd8, 8'd2);
        bus_write(6'd11, 8'd0);
        bus_write(6'd5, 8'h01);
        wait_cyc(34);
        @(negedge clk);
        adr = 6'd0;
        we  = 1'b0;
        stb = 1'b1;
        @(posedge clk);
        #1;
        check("t5_ack", {31'd0, ack}, 32'd1);
        check("t5_dat", {24'd0, dat_r}, 32'd3);
        check("t5_irq", {31'd0, irq}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ack", {31'd0, ack}, 32'd0);
        check("t5_rst_dat", {24'd0, dat_r}, 32'd0);
        check("t5_rst_irq", {31'd0, irq}, 32'd0);
        stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(6'd0, rv, rk);  check("t5_ticks0", {24'd0, rv}, 32'd0);
        bus_read(6'd4, rv, rk);  check("t5_pend0", {24'd0, rv}, 32'd0);
        bus_read(6'd12, rv, rk); check("t5_ctrl0", {24'd0, rv}, 32'd0);

`ifdef TIMER_CAPTURE_EN
        // 6: capture at tick 77
        do_reset();
        wait_cyc(775);
        cap_in = 1'b1;
        wait_cyc(778);
        cap_in = 1'b0;
        wait_cyc(790);
        bus_read(6'd60, rv, rk); check("t6_flag_set", {24'd0, rv}, 32'd1);
        bus_read(6'd56, rv, rk); check("t6_cap", {24'd0, rv}, 32'd77);
        bus_read(6'd60, rv, rk); check("t6_flag_clr", {24'd0, rv}, 32'd0);
        bus_read(6'd57, rv, rk); check("t6_cap_b1", {24'd0, rv}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_multi_wb8.md
Name: timer_multi_wb8

Overview:
Multi-channel millisecond timer on the 8-bit Wishbone peripheral bus. It is the parametrised successor to the single-compare system timer.
- Free-running tick counter with configurable tick rate.
- CHANNELS independent compare channels, each one-shot or periodic auto-reload.
- Per-channel pending/enable masks combined into one CPU interrupt line.

Parameters:
CLOCKFREQ, 25000000, input clock frequency in Hz
TICKHZ, 1000, tick rate of the time counter in Hz; CLOCKFREQ/TICKHZ must be >= 2
CHANNELS, 4, number of compare channels, 1..7 (1..6 when TIMER_CAPTURE_EN is defined)

Ports:
CLK_I  in  1  system clock
RST_N_I  in  1  reset; one clock, asynchronous assert, active-low
ADR_I  in  6  byte address
DAT_I  in  8  write data
STB_I  in  1  strobe
WE_I  in  1  write enable
ACK_O  out  1  acknowledge
DAT_O  out  8  read data
O_interrupt  out  1  level interrupt request
I_capture  in  1  capture input (only present with TIMER_CAPTURE_EN)

Behaviour:
- Reset (RST_N_I low, async): all registers 0; ACK_O=0, DAT_O=0, O_interrupt=0; every channel disarmed.
- Prescaler: counts 0..CLOCKFREQ/TICKHZ-1. On terminal count it wraps to 0 and `ticks` (32 bit) increments, wrapping 0xFFFFFFFF->0.
- Bus: every cycle ACK_O <= STB_I. Reads register DAT_O, so data and ACK_O are valid one cycle after STB_I. Writes take effect on that same edge.
- Unmapped addresses read 0; writes to them are ignored.
- Global map (addresses 0..7):
  - 0..3: ticks, little-endian. Reading byte 0 returns ticks[7:0] and snapshots ticks[31:8]; bytes 1..3 return the snapshot.
  - 4: PENDING[CHANNELS-1:0]. Read returns the bits; write is write-1-to-clear.
  - 5: IE[CHANNELS-1:0], read/write.
  - 6..7: read 0.
- Channel c map, base B=8*(c+1):
  - B+0..B+3: COMPARE[31:0], little-endian, read/write. Writing B+3 also sets ARMED.
  - B+4: CTRL, read/write. bit0=ARMED, bit1=PERIODIC; other bits read 0.
  - B+5..B+6: PERIOD[15:0], read/write.
  - B+7: read 0.
- Match: every cycle, for each channel with ARMED=1 and ticks==COMPARE:
  - PENDING[c] <= 1.
  - One-shot (PERIODIC=0) or PERIOD==0: ARMED <= 0.
  - Periodic with PERIOD!=0: COMPARE <= COMPARE + PERIOD (mod 2^32, wrap allowed); ARMED stays 1.
  - A single match event therefore sets pending once, never repeatedly.
- O_interrupt registered: O_interrupt <= |(PENDING & IE), one cycle latency.
- Simultaneous events, same cycle:
  - Match-set and W1C on the same PENDING bit: set wins, bit stays 1.
  - Bus write to COMPARE or CTRL and a match on that channel: the bus write wins for the written byte or field. Match-driven updates to the other fields still apply.
  - Writing ARMED=0 cancels a match in the same cycle; PENDING is still set.
- Arming with COMPARE already in the past waits for ticks to wrap around; no immediate fire.
- Reset mid-transaction: ACK_O drops immediately and all state clears; the bus master must retry.

Optional Feature:
Macro TIMER_CAPTURE_EN.
- Defined:
  - I_capture port added; synchronised by a 2-flop synchroniser.
  - A synchronised rising edge latches ticks into CAPTURE[31:0] and sets CAPFLAG.
  - CAPTURE readable at 56..59, little-endian. Reading byte 56 clears CAPFLAG.
  - CAPFLAG readable at 60 bit0 and ORed into O_interrupt when IE bit7 is set.
  - CHANNELS is limited to 6.
- Undefined: no port, no capture logic; addresses 56..60 behave per the normal map or read 0.

Test Plan:
1. CLOCKFREQ=10000, TICKHZ=1000; run 25 ticks, read 0..3 -> 25,0,0,0. Byte 1 is read after ticks reaches 256 -> returns the snapshot, unchanged.
2. Ch0 COMPARE=40, write B+3 (arms), IE=1 -> at ticks 40: PENDING=0x01, O_interrupt=1 one cycle later, CTRL.ARMED=0. Write 0x01 to addr 4 -> O_interrupt=0.
3. Ch1 periodic, PERIOD=10, COMPARE=100 -> PENDING[1] sets at 100, 110, 120. COMPARE reads 110 after the first hit. PERIOD=0 -> ch1 fires once, then disarms.
4. Match on ch0 in the same cycle as a W1C of bit0 -> PENDING[0]=1 afterwards.
5. Assert RST_N_I low mid-way through a read strobe -> ACK_O, DAT_O, O_interrupt, ticks all 0 immediately, without waiting for a clock edge.
6. (TIMER_CAPTURE_EN) Pulse I_capture at ticks 77 -> addr 56 reads 77, addr 60 bit0=1 before the read, 0 after.
